// File: rtl/fpu16_mul_add.sv
// fpu16_mul_add: binary16 multiply / add unit with a one-cycle registered result.
//   clk    : clock, all state updates on the rising edge
//   rst    : asynchronous active-high reset, clears result and valid
//   en     : operand capture enable
//   op     : 0 = multiply, 1 = add
//   a, b   : IEEE 754 binary16 operands
//   result : registered binary16 result, holds while en is low
//   valid  : high for the cycle after an enabled operation
// Subnormal inputs and results are flushed to signed zero; every NaN
// input returns the canonical quiet NaN. Rounding is nearest-even.
module fpu16_mul_add #(
  parameter int tam = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           op,
  input  logic [tam-1:0] a,
  input  logic [tam-1:0] b,
  output logic [tam-1:0] result,
  output logic           valid
);

  localparam logic [15:0] QNAN = 16'h7E00;

  // Round a {11-bit significand, guard, round, sticky} value and pack it,
  // saturating to infinity on overflow and flushing to zero on underflow.
  function automatic logic [15:0] pack(input logic s, input logic signed [7:0] e,
                                       input logic [13:0] m);
    logic              up;
    logic [11:0]       r;
    logic signed [7:0] e2;
    up = m[2] & (m[1] | m[0] | m[3]);
    r  = {1'b0, m[13:3]} + {11'b0, up};
    e2 = e;
    if (r[11]) begin
      e2 = e + 8'sd1;
      r  = r >> 1;
    end
    if (e2 >= 8'sd31)     pack = {s, 5'h1F, 10'h000};
    else if (e2 <= 8'sd0) pack = {s, 15'h0000};
    else                  pack = {s, e2[4:0], r[9:0]};
  endfunction

  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  assign a_nan  = (&a[14:10]) & (|a[9:0]);
  assign b_nan  = (&b[14:10]) & (|b[9:0]);
  assign a_inf  = (&a[14:10]) & ~(|a[9:0]);
  assign b_inf  = (&b[14:10]) & ~(|b[9:0]);
  assign a_zero = ~(|a[14:10]);
  assign b_zero = ~(|b[14:10]);

  // ---------------- multiply ----------------
  logic              m_sign;
  logic [21:0]       prod;
  logic signed [7:0] m_exp;
  logic signed [7:0] m_exp_n;
  logic [13:0]       m_sig;
  logic [15:0]       mul_res;

  assign m_sign = a[15] ^ b[15];
  assign prod   = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
  assign m_exp  = $signed({3'b000, a[14:10]}) + $signed({3'b000, b[14:10]}) - 8'sd15;

  always_comb begin
    m_exp_n = m_exp;
    m_sig   = {prod[20:10], prod[9], 1'b0, |prod[8:0]};
    if (prod[21]) begin
      m_exp_n = m_exp + 8'sd1;
      m_sig   = {prod[21:11], prod[10], 1'b0, |prod[9:0]};
    end
    if (a_nan | b_nan)                          mul_res = QNAN;
    else if ((a_inf & b_zero) | (b_inf & a_zero)) mul_res = QNAN;
    else if (a_inf | b_inf)                     mul_res = {m_sign, 5'h1F, 10'h000};
    else if (a_zero | b_zero)                   mul_res = {m_sign, 15'h0000};
    else                                        mul_res = pack(m_sign, m_exp_n, m_sig);
  end

  // ---------------- add ----------------
  logic [14:0]       a_mag, b_mag;
  logic [15:0]       x, y;
  logic [4:0]        d;
  logic [13:0]       ax, ay_full, ay_sh, mask;
  logic [14:0]       sum;
  logic [3:0]        lz;
  logic              found;
  logic [13:0]       norm;
  logic signed [7:0] s_exp;
  logic [15:0]       add_res;

  // Subnormals compare as zero magnitude so they never win the swap.
  assign a_mag = a_zero ? 15'h0000 : a[14:0];
  assign b_mag = b_zero ? 15'h0000 : b[14:0];
  assign x     = (b_mag > a_mag) ? {b[15], b_mag} : {a[15], a_mag};
  assign y     = (b_mag > a_mag) ? {a[15], a_mag} : {b[15], b_mag};
  assign d     = x[14:10] - y[14:10];
  assign ax    = {1'b1, x[9:0], 3'b000};
  assign ay_full = {1'b1, y[9:0], 3'b000};
  // Shift distances of 14 or more leave the whole operand in the sticky bit.
  assign mask  = (14'd1 << d) - 14'd1;

  always_comb begin
    ay_sh    = ay_full >> d;
    ay_sh[0] = ay_sh[0] | (|(ay_full & mask));
    if (x[15] ^ y[15]) sum = {1'b0, ax} - {1'b0, ay_sh};
    else               sum = {1'b0, ax} + {1'b0, ay_sh};

    lz    = 4'd0;
    found = 1'b0;
    for (int i = 13; i >= 0; i--) begin
      if (!found) begin
        if (sum[i]) found = 1'b1;
        else        lz = lz + 4'd1;
      end
    end

    if (sum[14]) begin
      norm  = {sum[14:2], sum[1] | sum[0]};
      s_exp = $signed({3'b000, x[14:10]}) + 8'sd1;
    end else begin
      norm  = sum[13:0] << lz;
      s_exp = $signed({3'b000, x[14:10]}) - $signed({4'b0000, lz});
    end

    if (a_nan | b_nan)                        add_res = QNAN;
    else if (a_inf & b_inf & (a[15] != b[15])) add_res = QNAN;
    else if (a_inf)                           add_res = a[15:0];
    else if (b_inf)                           add_res = b[15:0];
    else if (a_zero & b_zero)                 add_res = {a[15] & b[15], 15'h0000};
    else if (a_zero)                          add_res = b[15:0];
    else if (b_zero)                          add_res = a[15:0];
    else if (sum == 15'h0000)                 add_res = 16'h0000;
    else                                      add_res = pack(x[15], s_exp, norm);
  end

  // ---------------- output register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
      valid  <= 1'b0;
    end else begin
      valid <= en;
      if (en) result <= op ? add_res : mul_res;
    end
  end

endmodule

// File: tb/tb_fpu16_mul_add.sv
// Testbench for fpu16_mul_add: directed vectors, special cases, random
// back-to-back traffic against a real-arithmetic reference, enable/hold
// and asynchronous reset behaviour.
module tb_fpu16_mul_add;

  logic        clk;
  logic        rst;
  logic        en;
  logic        op;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] result;
  logic        valid;

  int total = 0;
  int bad   = 0;

  fpu16_mul_add #(.tam(16)) dut (
    .clk(clk), .rst(rst), .en(en), .op(op),
    .a(a), .b(b), .result(result), .valid(valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic bit is_nan(input logic [15:0] h);
    return (h[14:10] == 5'h1F) && (h[9:0] != 10'h0);
  endfunction
  function automatic bit is_inf(input logic [15:0] h);
    return (h[14:10] == 5'h1F) && (h[9:0] == 10'h0);
  endfunction
  function automatic bit is_zero(input logic [15:0] h);
    return h[14:10] == 5'h00;
  endfunction

  function automatic real h2r(input logic [15:0] h);
    real v;
    int  e;
    if (is_zero(h)) return 0.0;
    v = 1.0 + real'(h[9:0]) / 1024.0;
    e = int'(h[14:10]) - 15;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return h[15] ? -v : v;
  endfunction

  // Encode a nonzero real as binary16 with nearest-even, FTZ and saturation to inf.
  function automatic logic [15:0] r2h(input real v);
    logic s;
    real  m, rem;
    int   e, fi;
    s = (v < 0.0);
    m = s ? -v : v;
    e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    m   = m * 1024.0;
    fi  = $rtoi(m);
    rem = m - real'(fi);
    if (rem > 0.5 || (rem == 0.5 && (fi % 2) == 1)) fi++;
    if (fi == 2048) begin fi = 1024; e++; end
    if (e + 15 >= 31) return {s, 5'h1F, 10'h000};
    if (e + 15 <= 0)  return {s, 15'h0000};
    return {s, 5'(e + 15), 10'(fi - 1024)};
  endfunction

  function automatic logic [15:0] model(input logic o, input logic [15:0] x, input logic [15:0] y);
    real v;
    if (is_nan(x) || is_nan(y)) return 16'h7E00;
    if (!o) begin
      if ((is_inf(x) && is_zero(y)) || (is_inf(y) && is_zero(x))) return 16'h7E00;
      if (is_inf(x) || is_inf(y)) return {x[15] ^ y[15], 15'h7C00};
      if (is_zero(x) || is_zero(y)) return {x[15] ^ y[15], 15'h0000};
      return r2h(h2r(x) * h2r(y));
    end
    if (is_inf(x) && is_inf(y) && x[15] != y[15]) return 16'h7E00;
    if (is_inf(x)) return x;
    if (is_inf(y)) return y;
    if (is_zero(x) && is_zero(y)) return {x[15] & y[15], 15'h0000};
    v = h2r(x) + h2r(y);
    if (v == 0.0) return 16'h0000;
    return r2h(v);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic e, input logic o, input logic [15:0] x, input logic [15:0] y);
    en = e; op = o; a = x; b = y;
  endtask

  function automatic logic [15:0] rand_half();
    logic [15:0] specials [8];
    specials = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00, 16'h7E00, 16'h0001, 16'h7BFF, 16'h0400};
    if ($urandom_range(0, 7) == 0) return specials[$urandom_range(0, 7)];
    return 16'($urandom);
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 1'b0, 16'h3C00, 16'h4000);
    #1;
    total++;
    if (result !== 16'h0000 || valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_async result=%h valid=%b want 0000/0", result, valid);
    end
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (result !== 16'h0000 || valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_held result=%h valid=%b want 0000/0", result, valid);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (result !== 16'h4000 || valid !== 1'b1) begin
      bad++;
      $display("FAIL reset_first_op result=%h valid=%b want 4000/1", result, valid);
    end
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic        o;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] exp;
  } vec_t;

  task automatic test_directed();
    vec_t v [18];
    v = '{
      '{1'b0, 16'h3C00, 16'h4000, 16'h4000},
      '{1'b0, 16'h3E00, 16'h3E00, 16'h4080},
      '{1'b1, 16'h3C00, 16'h3C00, 16'h4000},
      '{1'b1, 16'h3C00, 16'h1000, 16'h3C00},
      '{1'b1, 16'h3C00, 16'hBC00, 16'h0000},
      '{1'b0, 16'h7BFF, 16'h4000, 16'h7C00},
      '{1'b0, 16'h7C00, 16'h0000, 16'h7E00},
      '{1'b1, 16'h7C00, 16'hFC00, 16'h7E00},
      '{1'b1, 16'h7E01, 16'h3C00, 16'h7E00},
      '{1'b0, 16'h0400, 16'h0400, 16'h0000},
      '{1'b1, 16'h0001, 16'h0000, 16'h0000},
      '{1'b1, 16'h8000, 16'h8000, 16'h8000},
      '{1'b0, 16'h8000, 16'h3C00, 16'h8000},
      '{1'b0, 16'hFC00, 16'h4000, 16'hFC00},
      '{1'b1, 16'h7C00, 16'h3C00, 16'h7C00},
      '{1'b1, 16'h3C01, 16'h1000, 16'h3C02},
      '{1'b1, 16'h7BFF, 16'h7BFF, 16'h7C00},
      '{1'b0, 16'hBC00, 16'h0000, 16'h8000}
    };
    foreach (v[i]) begin
      drive(1'b1, v[i].o, v[i].x, v[i].y);
      @(posedge clk);
      #1;
      total++;
      if (result !== v[i].exp || valid !== 1'b1) begin
        bad++;
        $display("FAIL directed_%0d op=%b a=%h b=%h result=%h valid=%b want %h/1",
                 i, v[i].o, v[i].x, v[i].y, result, valid, v[i].exp);
      end
    end
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    @(posedge clk);
    #1;
  endtask

  // Continuous en=1 stream: a new random op every cycle, each checked one cycle later.
  task automatic test_back_to_back_random();
    logic [15:0] x, y, want;
    logic        o;
    for (int i = 0; i < 400; i++) begin
      o = 1'($urandom);
      x = rand_half();
      y = rand_half();
      if ($urandom_range(0, 1) == 1) y[14:10] = x[14:10] - 5'($urandom_range(0, 2));
      want = model(o, x, y);
      drive(1'b1, o, x, y);
      @(posedge clk);
      #1;
      total++;
      if (result !== want || valid !== 1'b1) begin
        bad++;
        $display("FAIL random_%0d op=%b a=%h b=%h result=%h valid=%b want %h/1",
                 i, o, x, y, result, valid, want);
      end
    end
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    @(posedge clk);
    #1;
  endtask

  task automatic test_enable_hold();
    logic [15:0] want [3];
    logic [15:0] xs [3];
    xs = '{16'h4200, 16'h4400, 16'hC500};
    for (int i = 0; i < 3; i++) begin
      want[i] = model(1'b0, xs[i], 16'h3E00);
      drive(1'b1, 1'b0, xs[i], 16'h3E00);
      @(posedge clk);
      #1;
      total++;
      if (result !== want[i] || valid !== 1'b1) begin
        bad++;
        $display("FAIL hold_op_%0d result=%h valid=%b want %h/1", i, result, valid, want[i]);
      end
    end
    // en low: op and operands wiggle but nothing is captured.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'($urandom), 16'($urandom), 16'($urandom));
      @(posedge clk);
      #1;
      total++;
      if (result !== want[2] || valid !== 1'b0) begin
        bad++;
        $display("FAIL hold_idle_%0d result=%h valid=%b want %h/0", i, result, valid, want[2]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    drive(1'b1, 1'b1, 16'h3C00, 16'h3C00);
    @(posedge clk);
    #1;
    total++;
    if (result !== 16'h4000 || valid !== 1'b1) begin
      bad++;
      $display("FAIL midrst_pre result=%h valid=%b want 4000/1", result, valid);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (result !== 16'h0000 || valid !== 1'b0) begin
      bad++;
      $display("FAIL midrst_async result=%h valid=%b want 0000/0", result, valid);
    end
    drive(1'b1, 1'b0, 16'h3C00, 16'h4000);
    @(posedge clk);
    #1;
    total++;
    if (result !== 16'h0000 || valid !== 1'b0) begin
      bad++;
      $display("FAIL midrst_discard result=%h valid=%b want 0000/0", result, valid);
    end
    rst = 1'b0;
    drive(1'b1, 1'b0, 16'h3E00, 16'h3E00);
    @(posedge clk);
    #1;
    total++;
    if (result !== 16'h4080 || valid !== 1'b1) begin
      bad++;
      $display("FAIL midrst_after result=%h valid=%b want 4080/1", result, valid);
    end
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    @(posedge clk);
    #1;
    total++;
    if (valid !== 1'b0) begin
      bad++;
      $display("FAIL midrst_idle valid=%b want 0", valid);
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    op  = 1'b0;
    a   = 16'h0000;
    b   = 16'h0000;
    test_reset();
    test_directed();
    test_back_to_back_random();
    test_enable_hold();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
